// File: rtl/audio_seq_player.sv
// Sample-address sequencer: waits for codec init, then walks start..end one address per slot.
// Optional clip looping is enabled by defining AUDIO_SEQ_LOOP_EN.
module audio_seq_player #(
    parameter int ADDR_W     = 17,
    parameter int DIV_W      = 16,
    parameter int SAMPLE_DIV = 128
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              INIT_FINISH,
    output logic              INIT,
    input  logic              data_over,
    input  logic              play,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] Add,
    output logic              sample_req,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {WAIT_INIT, IDLE, RUN} state_t;

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(SAMPLE_DIV - 1);

    state_t            state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] add_q, start_q, end_q;
    logic              init_q, busy_q, req_q, done_q, err_q;
    logic              loop_eff;
    logic              tick;

`ifdef AUDIO_SEQ_LOOP_EN
    assign loop_eff = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign loop_eff    = 1'b0;
`endif

    // A slot ends every SAMPLE_DIV cycles; it only advances if the codec is ready.
    assign tick = (cnt_q == CNT_LAST) && data_over;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= WAIT_INIT;
            cnt_q   <= '0;
            add_q   <= '0;
            start_q <= '0;
            end_q   <= '0;
            init_q  <= 1'b1;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                WAIT_INIT: begin
                    if (INIT_FINISH) begin
                        state_q <= IDLE;
                        init_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (play) begin
                        if (start_addr <= end_addr) begin
                            start_q <= start_addr;
                            end_q   <= end_addr;
                            add_q   <= start_addr;
                            cnt_q   <= '0;
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Abort wins over a coincident tick: no advance, no done.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + DIV_W'(1);
                        if (tick) begin
                            if (add_q != end_q) begin
                                add_q <= add_q + ADDR_W'(1);
                                req_q <= 1'b1;
                            end else if (loop_eff) begin
                                add_q <= start_q;
                                req_q <= 1'b1;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_INIT;
                    init_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign INIT       = init_q;
    assign Add        = add_q;
    assign sample_req = req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_audio_seq_player.sv
// Randomized + directed bench for audio_seq_player against a behavioural playback model.
module tb_audio_seq_player;

    localparam int AW  = 17;
    localparam int DIV = 4;
`ifdef AUDIO_SEQ_LOOP_EN
    localparam bit LOOP_ON = 1'b1;
`else
    localparam bit LOOP_ON = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset, INIT_FINISH, data_over, play, stop, loop;
    logic [AW-1:0] start_addr, end_addr;
    logic          INIT, sample_req, busy, done, err;
    logic [AW-1:0] Add;

    audio_seq_player #(.ADDR_W(AW), .DIV_W(16), .SAMPLE_DIV(DIV)) dut (
        .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .INIT(INIT),
        .data_over(data_over), .play(play), .stop(stop), .loop(loop),
        .start_addr(start_addr), .end_addr(end_addr), .Add(Add),
        .sample_req(sample_req), .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: "is the codec initialised", "is a clip playing", where in the slot we are.
    bit m_ready, m_playing, m_req, m_done, m_err;
    int m_add, m_first, m_last, m_slot_pos;

    int req_addrs[$];
    int done_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_advance();
        m_req = 0; m_done = 0; m_err = 0;
        if (Reset) begin
            m_ready = 0; m_playing = 0; m_add = 0; m_first = 0; m_last = 0; m_slot_pos = 0;
        end else if (!m_ready) begin
            if (INIT_FINISH) m_ready = 1;
        end else if (!m_playing) begin
            if (play) begin
                if (int'(start_addr) <= int'(end_addr)) begin
                    m_playing = 1; m_first = start_addr; m_last = end_addr;
                    m_add = start_addr; m_slot_pos = 0;
                end else m_err = 1;
            end
        end else if (stop) begin
            m_playing = 0; m_slot_pos = 0;
        end else begin
            bit slot_end;
            slot_end   = (m_slot_pos == DIV - 1);
            m_slot_pos = (m_slot_pos + 1) % DIV;
            if (slot_end && data_over) begin
                if (m_add != m_last) begin
                    m_add++; m_req = 1;
                end else if (LOOP_ON && loop) begin
                    m_add = m_first; m_req = 1;
                end else begin
                    m_playing = 0; m_done = 1;
                end
            end
        end
    endtask

    // One clock: model moves with the applied inputs, then every output is compared.
    task automatic step();
        model_advance();
        @(posedge Clk);
        #1;
        check("INIT", INIT, !m_ready);
        check("busy", busy, m_playing);
        check("Add", Add, m_add);
        check("sample_req", sample_req, m_req);
        check("done", done, m_done);
        check("err", err, m_err);
        if (sample_req) req_addrs.push_back(Add);
        if (done) done_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_play(input int s, input int e);
        start_addr = AW'(s); end_addr = AW'(e); play = 1;
        step();
        play = 0;
    endtask

    initial begin
        Reset = 1; INIT_FINISH = 0; data_over = 1; play = 0; stop = 0; loop = 0;
        start_addr = '0; end_addr = '0;
        steps(2);
        check("reset Add", Add, 0);
        check("reset INIT", INIT, 1);
        Reset = 0;

        // Init handshake: INIT stays high until one cycle after INIT_FINISH.
        play = 1;
        steps(10);
        play = 0;
        check("INIT held", INIT, 1);
        INIT_FINISH = 1;
        step();
        INIT_FINISH = 0;
        check("INIT dropped", INIT, 0);
        check("idle busy", busy, 0);

        // One-shot 5..7.
        req_addrs.delete(); done_cnt = 0;
        start_play(5, 7);
        check("first Add", Add, 5);
        steps(16);
        check("req count", req_addrs.size(), 2);
        if (req_addrs.size() == 2) begin
            check("req addr0", req_addrs[0], 6);
            check("req addr1", req_addrs[1], 7);
        end
        check("done once", done_cnt, 1);
        check("end Add", Add, 7);
        check("end busy", busy, 0);

        // Loop request: model decides whether the build honours it.
        loop = 1;
        start_play(5, 7);
        steps(30);
        loop = 0;
        stop = 1; step(); stop = 0;

        // Codec not ready on the second slot.
        start_play(5, 7);
        steps(4);
        data_over = 0; steps(4); data_over = 1;
        steps(12);

        // Stop coincident with the tick at Add=6.
        start_play(5, 7);
        steps(4);
        check("pre-stop Add", Add, 6);
        steps(3);
        stop = 1; step(); stop = 0;
        check("stop Add", Add, 6);
        check("stop req", sample_req, 0);
        check("stop busy", busy, 0);

        // Single-address clip.
        start_play(3, 3);
        steps(6);
        check("single done Add", Add, 3);

        // Rejected play, then reset mid-run.
        start_play(9, 3);
        check("err pulse", err, 1);
        check("err busy", busy, 0);
        start_play(2, 9);
        steps(5);
        Reset = 1; step(); Reset = 0;
        check("mid-run reset Add", Add, 0);
        check("mid-run reset INIT", INIT, 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            Reset       = ($urandom_range(0, 499) == 0);
            INIT_FINISH = ($urandom_range(0, 2) == 0);
            play        = ($urandom_range(0, 7) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            loop        = $urandom_range(0, 1);
            data_over   = ($urandom_range(0, 4) != 0);
            start_addr  = AW'($urandom_range(0, 12));
            end_addr    = AW'($urandom_range(0, 12));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
